stage_sequencer: RTL

- Multicycle control unit for the 16-bit RISC-V core; the consumer of the 3-bit stage count (Cnt) produced by the timing generator.
- Latches the instruction class at fetch and decodes Cnt plus class into per-stage datapath strobes.
- Drives LastStage back to the timing generator to end each instruction.
- Tracks halt, illegal-opcode and retired-instruction status.

---
 rtl/riscv16_defs.sv | 92 +++++++++
 rtl/stage_sequencer_decode.sv | 92 +++++++++
 rtl/stage_sequencer.sv | 136 +++++++++++++
 3 files changed

// File: rtl/riscv16_defs.sv
// ---------------------------------------------------------------------------
// riscv16_defs
// Shared definitions for the 16-bit RISC-V multicycle control path.
//   - opcode constants (Instr[15:12])
//   - ALU function codes and PC source select codes
//   - instruction class encoding latched by the stage sequencer at fetch
//   - the per-stage datapath strobe bundle
//   - helpers: opcode -> class decode, class -> final stage number
// ---------------------------------------------------------------------------
package riscv16_defs;

    // Opcodes, Instr[15:12]
    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_ADDI  = 4'b0001;
    localparam logic [3:0] OP_LW    = 4'b0010;
    localparam logic [3:0] OP_SW    = 4'b0011;
    localparam logic [3:0] OP_BEQ   = 4'b0100;
    localparam logic [3:0] OP_JAL   = 4'b0101;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    // ALU function codes
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;

    // PC source select
    localparam logic [1:0] PCSRC_SEQ    = 2'b00;  // PC + 1
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;  // branch target
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;  // jump target

    // Instruction class held for the lifetime of one instruction.
    // CLS_NOP exists only as the post-reset class; no opcode decodes to it.
    typedef enum logic [3:0] {
        CLS_NOP     = 4'd0,
        CLS_RTYPE   = 4'd1,
        CLS_ADDI    = 4'd2,
        CLS_LW      = 4'd3,
        CLS_SW      = 4'd4,
        CLS_BEQ     = 4'd5,
        CLS_JAL     = 4'd6,
        CLS_HALT    = 4'd7,
        CLS_ILLEGAL = 4'd8
    } instr_class_t;

    // Datapath strobes produced each cycle
    typedef struct packed {
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       alu_src;
        logic [2:0] alu_op;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem_to_reg;
    } strobes_t;

    localparam strobes_t STROBES_IDLE = '0;

    // Opcode -> instruction class; anything unlisted is illegal.
    function automatic instr_class_t decode_class(input logic [3:0] opcode);
        instr_class_t cls;
        case (opcode)
            OP_RTYPE: cls = CLS_RTYPE;
            OP_ADDI:  cls = CLS_ADDI;
            OP_LW:    cls = CLS_LW;
            OP_SW:    cls = CLS_SW;
            OP_BEQ:   cls = CLS_BEQ;
            OP_JAL:   cls = CLS_JAL;
            OP_HALT:  cls = CLS_HALT;
            default:  cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

    // Stage count on which each class completes.
    function automatic logic [2:0] last_stage_of(input instr_class_t cls);
        logic [2:0] stage;
        case (cls)
            CLS_RTYPE:   stage = 3'd3;
            CLS_ADDI:    stage = 3'd3;
            CLS_LW:      stage = 3'd4;
            CLS_SW:      stage = 3'd3;
            CLS_BEQ:     stage = 3'd2;
            CLS_JAL:     stage = 3'd2;
            CLS_HALT:    stage = 3'd1;
            CLS_ILLEGAL: stage = 3'd1;
            default:     stage = 3'd0;  // CLS_NOP: fetch-only
        endcase
        return stage;
    endfunction

endpackage

// File: rtl/stage_sequencer_decode.sv
// ---------------------------------------------------------------------------
// stage_sequencer_decode
// Purely combinational translation of (class, stage count, zero flag) into
// the datapath strobes for that cycle and the "this is the final stage" flag.
//
// Ports:
//   cls        in   latched instruction class
//   funct      in   latched Instr[2:0], ALU function for R-type
//   cnt        in   stage count (0 = fetch)
//   zero       in   ALU zero flag, qualifies the branch PC write
//   strobes    out  datapath strobes for this cycle
//   last_stage out  cnt is the final stage of cls, or the watchdog stage
// ---------------------------------------------------------------------------
module stage_sequencer_decode
    import riscv16_defs::*;
#(
    parameter int LAST_MAX = 7
) (
    input  instr_class_t cls,
    input  logic [2:0]   funct,
    input  logic [2:0]   cnt,
    input  logic         zero,
    output strobes_t     strobes,
    output logic         last_stage
);

    localparam logic [2:0] LAST_MAX_CNT = 3'(LAST_MAX);

    always_comb begin
        strobes    = STROBES_IDLE;
        last_stage = (cnt == last_stage_of(cls)) || (cnt == LAST_MAX_CNT);

        if (cnt == 3'd0) begin
            // Fetch is class-independent, so a stale class from the previous
            // instruction can never leak strobes into this cycle.
            strobes.ir_write = 1'b1;
            strobes.pc_write = 1'b1;
            strobes.pc_src   = PCSRC_SEQ;
        end else if (cnt != LAST_MAX_CNT) begin
            // The watchdog stage is excluded so a runaway count does no writes.
            case (cls)
                CLS_RTYPE, CLS_ADDI: begin
                    if (cnt == 3'd2) begin
                        strobes.alu_op  = (cls == CLS_RTYPE) ? funct : ALU_ADD;
                        strobes.alu_src = (cls == CLS_ADDI);
                    end else if (cnt == 3'd3) begin
                        strobes.reg_write  = 1'b1;
                        strobes.mem_to_reg = 1'b0;
                    end
                end
                CLS_LW: begin
                    if (cnt == 3'd2) begin
                        strobes.alu_op  = ALU_ADD;
                        strobes.alu_src = 1'b1;
                    end else if (cnt == 3'd3) begin
                        strobes.mem_read = 1'b1;
                    end else if (cnt == 3'd4) begin
                        strobes.reg_write  = 1'b1;
                        strobes.mem_to_reg = 1'b1;
                    end
                end
                CLS_SW: begin
                    if (cnt == 3'd2) begin
                        strobes.alu_op  = ALU_ADD;
                        strobes.alu_src = 1'b1;
                    end else if (cnt == 3'd3) begin
                        strobes.mem_write = 1'b1;
                    end
                end
                CLS_BEQ: begin
                    if (cnt == 3'd2) begin
                        strobes.alu_op   = ALU_SUB;
                        strobes.alu_src  = 1'b0;
                        strobes.pc_write = zero;
                        strobes.pc_src   = PCSRC_BRANCH;
                    end
                end
                CLS_JAL: begin
                    if (cnt == 3'd2) begin
                        strobes.reg_write = 1'b1;  // link register
                        strobes.pc_write  = 1'b1;
                        strobes.pc_src    = PCSRC_JUMP;
                    end
                end
                default: begin
                    // NOP, HALT and illegal opcodes produce no writes after fetch
                end
            endcase
        end
    end

endmodule

// File: rtl/stage_sequencer.sv
// ---------------------------------------------------------------------------
// stage_sequencer
// Multicycle control unit for the 16-bit RISC-V core. Latches the instruction
// class at fetch (Cnt = 0), decodes the stage count into datapath strobes,
// signals the timing generator when the instruction is complete, and keeps
// halt / illegal-opcode / retired-instruction status.
//
// Ports:
//   clk        in   system clock
//   Rst        in   asynchronous active-high reset
//   Cnt[2:0]   in   stage count from the timing generator (0 = fetch)
//   Instr[15:0] in  instruction memory output (opcode [15:12], funct [2:0])
//   Zero       in   ALU zero flag
//   IRWrite, PCWrite, PCSrc[1:0], ALUSrc, ALUOp[2:0], MemRead, MemWrite,
//   RegWrite, MemToReg  out  datapath strobes (combinational)
//   LastStage  out  final stage of the current instruction
//   Halted     out  sticky, HALT executed
//   IllegalOp  out  sticky, undefined opcode seen
//   RetireCnt  out  retired-instruction counter, wraps
// ---------------------------------------------------------------------------
module stage_sequencer
    import riscv16_defs::*;
#(
    parameter int RETIRE_W = 16,
    parameter int LAST_MAX = 7
) (
    input  logic                clk,
    input  logic                Rst,
    input  logic [2:0]          Cnt,
    input  logic [15:0]         Instr,
    input  logic                Zero,
    output logic                IRWrite,
    output logic                PCWrite,
    output logic [1:0]          PCSrc,
    output logic                ALUSrc,
    output logic [2:0]          ALUOp,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                RegWrite,
    output logic                MemToReg,
    output logic                LastStage,
    output logic                Halted,
    output logic                IllegalOp,
    output logic [RETIRE_W-1:0] RetireCnt
);

    instr_class_t        cls_reg;
    logic [2:0]          funct_reg;
    logic                halted_reg;
    logic                illegal_reg;
    logic [RETIRE_W-1:0] retire_cnt_reg;
    logic [RETIRE_W-1:0] retire_cnt_next;

    strobes_t            dec_strobes;
    logic                dec_last_stage;
    strobes_t            strobes;
    logic                last_stage;
    logic                retire_fire;

    // Instr[11:3] carries register/immediate fields used only by the datapath.
    logic                instr_unused;
    assign instr_unused = ^Instr[11:3];

    stage_sequencer_decode #(
        .LAST_MAX (LAST_MAX)
    ) u_decode (
        .cls        (cls_reg),
        .funct      (funct_reg),
        .cnt        (Cnt),
        .zero       (Zero),
        .strobes    (dec_strobes),
        .last_stage (dec_last_stage)
    );

    // Reset kills every strobe immediately, including mid-instruction.
    // Once halted, only LastStage stays high so the timing generator parks
    // at Cnt = 0 without fetching.
    always_comb begin
        strobes    = STROBES_IDLE;
        last_stage = 1'b0;
        if (!Rst) begin
            if (halted_reg) begin
                last_stage = 1'b1;
            end else begin
                strobes    = dec_strobes;
                last_stage = dec_last_stage;
            end
        end
    end

    // The NOP class exists only between reset and the first fetch, so its
    // completion is not a real instruction retiring.
    assign retire_fire     = last_stage && !halted_reg && (cls_reg != CLS_NOP);
    assign retire_cnt_next = retire_cnt_reg + 1'b1;

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            cls_reg        <= CLS_NOP;
            funct_reg      <= 3'd0;
            halted_reg     <= 1'b0;
            illegal_reg    <= 1'b0;
            retire_cnt_reg <= '0;
        end else begin
            if (!halted_reg && (Cnt == 3'd0)) begin
                cls_reg   <= decode_class(Instr[15:12]);
                funct_reg <= Instr[2:0];
            end
            if (!halted_reg && (Cnt == 3'd1)) begin
                if (cls_reg == CLS_HALT) begin
                    halted_reg <= 1'b1;
                end
                if (cls_reg == CLS_ILLEGAL) begin
                    illegal_reg <= 1'b1;
                end
            end
            if (retire_fire) begin
                retire_cnt_reg <= retire_cnt_next;
            end
        end
    end

    assign IRWrite   = strobes.ir_write;
    assign PCWrite   = strobes.pc_write;
    assign PCSrc     = strobes.pc_src;
    assign ALUSrc    = strobes.alu_src;
    assign ALUOp     = strobes.alu_op;
    assign MemRead   = strobes.mem_read;
    assign MemWrite  = strobes.mem_write;
    assign RegWrite  = strobes.reg_write;
    assign MemToReg  = strobes.mem_to_reg;
    assign LastStage = last_stage;
    assign Halted    = halted_reg;
    assign IllegalOp = illegal_reg;
    assign RetireCnt = retire_cnt_reg;

endmodule
